// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO, models fixed MUL/DIV latency.
// Define MD_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops (9-12).
module md_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start_o,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rd
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_div_op;
    logic        is_mul_op;
    logic [63:0] prod;
    logic [63:0] mul_res;
    logic [63:0] div_res;

    // 64-bit product of the captured operands; signed for the MULT-family signed ops.
    function automatic logic [63:0] product(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sprod;
        logic        [63:0] uprod;
        sa    = {{32{a[31]}}, a};
        sb    = {{32{b[31]}}, b};
        sprod = sa * sb;
        uprod = {32'd0, a} * {32'd0, b};
        if (op == OP_MULT || op == OP_MADD || op == OP_MSUB) begin
            return sprod;
        end
        return uprod;
    endfunction

    // Returns {remainder, quotient}. Signed division goes through magnitudes so that
    // 0x80000000 / -1 yields 0x80000000 with a zero remainder instead of overflowing.
    function automatic logic [63:0] divide(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic        neg_q;
        logic        neg_r;
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] uq;
        logic [31:0] ur;
        if (op == OP_DIV) begin
            ua    = a[31] ? -a : a;
            ub    = b[31] ? -b : b;
            neg_q = a[31] ^ b[31];
            neg_r = a[31];
        end else begin
            ua    = a;
            ub    = b;
            neg_q = 1'b0;
            neg_r = 1'b0;
        end
        if (ub == 32'd0) begin
            return 64'd0;
        end
        uq = ua / ub;
        ur = ua % ub;
        return {(neg_r ? -ur : ur), (neg_q ? -uq : uq)};
    endfunction

    always_comb begin
        is_div_op = (md_op == OP_DIV) || (md_op == OP_DIVU);
        is_mul_op = (md_op == OP_MULT) || (md_op == OP_MULTU);
`ifdef MD_MADD_EN
        is_mul_op = is_mul_op || (md_op == OP_MADD) || (md_op == OP_MADDU) ||
                    (md_op == OP_MSUB) || (md_op == OP_MSUBU);
`endif
    end

    assign start_o = start & (is_mul_op | is_div_op) & ~busy_q;

    always_comb begin
        prod = product(op_q, a_q, b_q);
`ifdef MD_MADD_EN
        // Accumulation reads {hi,lo} as it stands at the commit edge.
        case (op_q)
            OP_MADD, OP_MADDU: mul_res = {hi_q, lo_q} + prod;
            OP_MSUB, OP_MSUBU: mul_res = {hi_q, lo_q} - prod;
            default:           mul_res = prod;
        endcase
`else
        mul_res = prod;
`endif
        div_res = divide(op_q, a_q, b_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start_o) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = md_op;
                    busy_d  = 1'b1;
                    state_d = is_div_op ? S_DIV : S_MUL;
                    cnt_d   = is_div_op ? DIV_CNT : MUL_CNT;
                end else if (md_op == OP_MTHI) begin
                    hi_d = A;
                end else if (md_op == OP_MTLO) begin
                    lo_d = A;
                end
            end
            S_MUL, S_DIV: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    if (state_q == S_MUL) begin
                        {hi_d, lo_d} = mul_res;
                    end else if (b_q != 32'd0) begin
                        {hi_d, lo_d} = div_res;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        md_rd = 32'd0;
        if (md_op == OP_MFHI) begin
            md_rd = hi_q;
        end else if (md_op == OP_MFLO) begin
            md_rd = lo_q;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit for the EX stage of the 5-stage MIPS pipeline; it owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU with operands already forwarded in EX.
- Models fixed multi-cycle latency and drives `busy`/`start_o`, which the stall unit uses to hold any MD-class instruction in ID.
- Also services MFHI/MFLO reads and MTHI/MTLO writes.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (and MADD family when enabled); legal range 1..15
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low (0 = reset asserted)
- start  input  1  qualifies md_op as a new long operation this cycle
- md_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- start_o  output  1  = start & long-op & ~busy (combinational; stall unit's state input)
- busy  output  1  registered; high while a long operation is in flight
- hi  output  32  HI register
- lo  output  32  LO register
- md_rd  output  32  combinational: hi when md_op=MFHI, lo when md_op=MFLO, else 0

Behaviour:
- Reset (async, reset=0): state IDLE, busy=0, cnt=0, hi=0, lo=0, internal result buffers=0. Takes effect immediately and aborts any in-flight operation; the uncommitted result is discarded.
- States and transitions:
  - IDLE → MUL on accepted start with op 1/2 (or 9–12): capture A, B, op; cnt=MUL_CYCLES; busy=1 from next edge.
  - IDLE → DIV on accepted start with op 3/4: cnt=DIV_CYCLES; busy=1 from next edge.
  - MUL/DIV: cnt decrements every cycle. When cnt reaches 1, that edge commits hi/lo, clears busy and returns to IDLE.
- Timing: start sampled at edge T0. busy=1 for cycles T0+1 … T0+N. The new hi/lo are visible and busy=0 from T0+N+1 onward.
- Accepted start: start=1, op in 1–4 (or 9–12), busy=0. A start while busy=1 is ignored; the stall unit guarantees this never occurs, and the bench checks it as an assertion.
- A long-op start with md_op outside 1–4 (and 9–12 when MD_MADD_EN is defined) is ignored.
- Arithmetic:
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (B=0): the operation still occupies DIV_CYCLES; hi/lo are left unchanged at commit.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no trap.
- MTHI/MTLO: when md_op=7/8 and busy=0 (start ignored), hi or lo = A at the edge. If busy=1 the write is dropped; the stall unit prevents this case.
- MFHI/MFLO: md_rd reflects the current register value combinationally. A read is never issued while busy because of the stall.
- Operands are captured at start; later changes on A/B do not affect the in-flight result.
- No simultaneous commit and new start: the first new start can be accepted at T0+N+1.

Optional Feature:
- Macro MD_MADD_EN.
- Defined:
  - ops 9–12 accepted with MUL_CYCLES latency.
  - MADD: {hi,lo} += signed A*B.
  - MADDU: {hi,lo} += unsigned A*B.
  - MSUB / MSUBU: {hi,lo} -= the corresponding product.
  - Accumulation is modulo 2^64 and uses the {hi,lo} value at commit time.
- Undefined: ops 9–12 are treated as NONE (no busy, no state change).

Test Plan:
- Reset then MULT A=0xFFFFFFFF B=0x00000002 → busy high exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU same operands → hi=0x00000001, lo=0xFFFFFFFE; MFHI drives md_rd=0x00000001.
- DIV A=0xFFFFFFF9 (−7) B=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU A=7 B=0 with prior hi=0x11, lo=0x22 → busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- MTLO A=0x12345678, then MFLO → md_rd=0x12345678. Start DIV, change A/B during busy → result uses the captured operands.
- Assert reset=0 at cycle 3 of a MULT → busy=0, hi=lo=0 immediately. With MD_MADD_EN: hi=0, lo=5, then MADD 3*4 → lo=0x11, hi=0.
